// File: rtl/reg_write_arbiter_if.sv
// Write-request bundle for reg_write_arbiter: two requesters
// (A = writeback, B = load/multi-cycle unit) with valid/grant handshakes.
interface reg_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_gnt;
  logic              b_req;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_gnt;

  modport master (
    output a_req, a_addr, a_data,
    output b_req, b_addr, b_data,
    input  a_gnt, b_gnt
  );

  modport slave (
    input  a_req, a_addr, a_data,
    input  b_req, b_addr, b_data,
    output a_gnt, b_gnt
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register file write port.
// REG_ARB_ZERO_INIT_EN enables zero-initialisation of every register after reset.
module reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  reg_write_arbiter_if.slave req_if,
  output logic              init_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data
);

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  logic              run;
  logic              pick_a;
  logic              pick_b;
  logic              last_q,  last_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;

`ifdef REG_ARB_ZERO_INIT_EN
  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;

  assign run       = (state_q == RUN);
  assign init_busy = (state_q == INIT);
`else
  assign run       = 1'b1;
  assign init_busy = 1'b0;
`endif

  // Ties go to whoever was not granted last; grants die with reset.
  assign pick_a = run && !reset && req_if.a_req &&
                  (!req_if.b_req || last_q == LAST_B);
  assign pick_b = run && !reset && req_if.b_req &&
                  (!req_if.a_req || last_q == LAST_A);

  assign req_if.a_gnt = pick_a;
  assign req_if.b_gnt = pick_b;

  assign wr_en      = wr_en_q;
  assign write_addr = addr_q;
  assign write_data = data_q;

  always_comb begin
    last_d  = last_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (1'b1)
      pick_a: begin
        last_d  = LAST_A;
        wr_en_d = 1'b1;
        addr_d  = req_if.a_addr;
        data_d  = req_if.a_data;
      end
      pick_b: begin
        last_d  = LAST_B;
        wr_en_d = 1'b1;
        addr_d  = req_if.b_addr;
        data_d  = req_if.b_data;
      end
      default: ;
    endcase
`ifdef REG_ARB_ZERO_INIT_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      wr_en_d = 1'b1;
      addr_d  = cnt_q;
      data_d  = '0;
      cnt_d   = cnt_q + ADDR_W'(1);
      if (cnt_q == {ADDR_W{1'b1}}) begin
        state_d = RUN;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= LAST_B;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef REG_ARB_ZERO_INIT_EN
      state_q <= INIT;
      cnt_q   <= '0;
`endif
    end else begin
      last_q  <= last_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef REG_ARB_ZERO_INIT_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; follows the
// REG_ARB_ZERO_INIT_EN setting of the build.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_busy;
  logic        wr_en;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] rf [16];
  int          n_checks = 0;
  int          n_errors = 0;

  reg_write_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  reg_write_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_if     (bus.slave),
    .init_busy  (init_busy),
    .wr_en      (wr_en),
    .write_addr (write_addr),
    .write_data (write_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) rf[write_addr] <= write_data;
  end

`ifdef REG_ARB_ZERO_INIT_EN
  localparam logic INIT_ON = 1'b1;
`else
  localparam logic INIT_ON = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.a_req  = 1'b0;
    bus.b_req  = 1'b0;
    bus.a_addr = '0;
    bus.b_addr = '0;
    bus.a_data = '0;
    bus.b_data = '0;
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle with reset low).
  task automatic do_reset();
    reset = 1'b1;
    idle_reqs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_reqs();
    bus.a_req = 1'b1;
    bus.b_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_wr_en: got %b want 0", wr_en);
    end
    n_checks++;
    if (write_addr !== 4'd0 || write_data !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_addr_data: got %h/%h want 0/0",
               write_addr, write_data);
    end
    n_checks++;
    if (init_busy !== INIT_ON) begin
      n_errors++;
      $display("FAIL reset_init_busy: got %b want %b", init_busy, INIT_ON);
    end
    n_checks++;
    if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_gnt: got a=%b b=%b want 0/0",
               bus.a_gnt, bus.b_gnt);
    end
    idle_reqs();
  endtask

  task automatic test_init();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      n_checks++;
      if (wr_en !== (c >= 1 && c <= 16)) begin
        n_errors++;
        $display("FAIL init_wr_en c%0d: got %b", c, wr_en);
      end
      if (c >= 1 && c <= 16) begin
        n_checks++;
        if (write_addr !== 4'(c - 1) || write_data !== 32'd0) begin
          n_errors++;
          $display("FAIL init_write c%0d: got %h/%h want %h/0",
                   c, write_addr, write_data, c - 1);
        end
      end
      n_checks++;
      if (init_busy !== (c < 16)) begin
        n_errors++;
        $display("FAIL init_busy c%0d: got %b", c, init_busy);
      end
      n_checks++;
      if (bus.a_gnt !== 1'b0 || bus.b_gnt !== 1'b0) begin
        n_errors++;
        $display("FAIL init_gnt c%0d: got %b/%b", c, bus.a_gnt, bus.b_gnt);
      end
      step();
    end
  endtask

  task automatic test_init_pending();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      if (c == 5) begin
        bus.a_req  = 1'b1;
        bus.a_addr = 4'd3;
        bus.a_data = 32'hDEAD_BEEF;
      end
      if (c == 17) bus.a_req = 1'b0;
      @(negedge clk);
      if (c >= 5 && c < 16) begin
        n_checks++;
        if (bus.a_gnt !== 1'b0) begin
          n_errors++;
          $display("FAIL pend_early_gnt c%0d: got %b want 0", c, bus.a_gnt);
        end
      end
      if (c == 16) begin
        n_checks++;
        if (bus.a_gnt !== 1'b1 || init_busy !== 1'b0) begin
          n_errors++;
          $display("FAIL pend_gnt c16: got gnt=%b busy=%b want 1/0",
                   bus.a_gnt, init_busy);
        end
      end
      if (c == 17) begin
        n_checks++;
        if (wr_en !== 1'b1 || write_addr !== 4'd3 ||
            write_data !== 32'hDEAD_BEEF) begin
          n_errors++;
          $display("FAIL pend_write c17: got %b/%h/%h want 1/3/deadbeef",
                   wr_en, write_addr, write_data);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid_init();
    int nxt;
    do_reset();
    repeat (8) step();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || write_addr !== 4'd7) begin
      n_errors++;
      $display("FAIL mid_pre_reset: got %b/%h want 1/7", wr_en, write_addr);
    end
    step();
    reset = 1'b0;
    nxt = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        n_checks++;
        if (write_addr !== 4'(nxt) || write_data !== 32'd0 || c == 0) begin
          n_errors++;
          $display("FAIL mid_write c%0d: got %h/%h want %h/0",
                   c, write_addr, write_data, nxt);
        end
        nxt++;
      end
      step();
    end
    n_checks++;
    if (nxt !== 16) begin
      n_errors++;
      $display("FAIL mid_write_count: got %0d want 16", nxt);
    end
  endtask

  task automatic test_noinit();
    do_reset();
    bus.b_req  = 1'b1;
    bus.b_addr = 4'd15;
    bus.b_data = 32'h5;
    @(negedge clk);
    n_checks++;
    if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0) begin
      n_errors++;
      $display("FAIL noinit_gnt: got a=%b b=%b want 0/1",
               bus.a_gnt, bus.b_gnt);
    end
    n_checks++;
    if (init_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL noinit_busy0: got %b want 0", init_busy);
    end
    step();
    bus.b_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || write_addr !== 4'd15 || write_data !== 32'h5) begin
      n_errors++;
      $display("FAIL noinit_write: got %b/%h/%h want 1/f/5",
               wr_en, write_addr, write_data);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b0 || init_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL noinit_idle: got wr_en=%b busy=%b want 0/0",
               wr_en, init_busy);
    end
    step();
  endtask

  // Expects last=B on entry so that A wins the first tie.
  task automatic test_round_robin();
    logic [31:0] exp_d;
    for (int i = 0; i < 5; i++) begin
      bus.a_req  = (i < 4);
      bus.b_req  = (i < 4);
      bus.a_addr = 4'd1;
      bus.b_addr = 4'd2;
      bus.a_data = 32'hA000 + i;
      bus.b_data = 32'hB000 + i;
      @(negedge clk);
      if (i < 4) begin
        n_checks++;
        if (bus.a_gnt !== (i % 2 == 0) || bus.b_gnt !== (i % 2 == 1)) begin
          n_errors++;
          $display("FAIL rr_gnt %0d: got a=%b b=%b", i, bus.a_gnt, bus.b_gnt);
        end
      end
      if (i > 0) begin
        exp_d = ((i - 1) % 2 == 0) ? 32'hA000 + (i - 1) : 32'hB000 + (i - 1);
        n_checks++;
        if (wr_en !== 1'b1 || write_addr !== 4'((i - 1) % 2 + 1) ||
            write_data !== exp_d) begin
          n_errors++;
          $display("FAIL rr_write %0d: got %b/%h/%h want 1/%h/%h", i,
                   wr_en, write_addr, write_data, (i - 1) % 2 + 1, exp_d);
        end
      end
      step();
    end
    idle_reqs();
  endtask

  task automatic test_same_addr();
    bus.a_req  = 1'b1;
    bus.a_addr = 4'd7;
    bus.a_data = 32'h1;
    bus.b_req  = 1'b1;
    bus.b_addr = 4'd7;
    bus.b_data = 32'h2;
    @(negedge clk);
    n_checks++;
    if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin
      n_errors++;
      $display("FAIL same_first: got a=%b b=%b want 1/0",
               bus.a_gnt, bus.b_gnt);
    end
    step();
    bus.a_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.b_gnt !== 1'b1 || wr_en !== 1'b1 || write_data !== 32'h1) begin
      n_errors++;
      $display("FAIL same_second: got b=%b wr=%b data=%h want 1/1/1",
               bus.b_gnt, wr_en, write_data);
    end
    step();
    bus.b_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wr_en !== 1'b1 || write_addr !== 4'd7 || write_data !== 32'h2) begin
      n_errors++;
      $display("FAIL same_write_b: got %b/%h/%h want 1/7/2",
               wr_en, write_addr, write_data);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (rf[7] !== 32'h2 || wr_en !== 1'b0) begin
      n_errors++;
      $display("FAIL same_final: got rf7=%h wr=%b want 2/0", rf[7], wr_en);
    end
    step();
  endtask

  initial begin
    test_reset();
`ifdef REG_ARB_ZERO_INIT_EN
    test_init();
`else
    test_noinit();
`endif
    test_round_robin();
    test_same_addr();
`ifdef REG_ARB_ZERO_INIT_EN
    test_init_pending();
    test_reset_mid_init();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Arbiter and sequencer for the single write port of the 16x32 register file. It zero-initialises every register after reset, then shares the write port between two requesters with a valid/grant handshake and round-robin priority. Requester A is the pipeline writeback; requester B is the load/multi-cycle unit. Its registered write outputs drive the register file's `wr_en`, `write_addr` and `write_data` directly.

## Interface
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 4: register address width; `NUM_REGS = 2**ADDR_W`.

Ports:
- `clk`  in  1  clock; everything is on its posedge.
- `reset`  in  1  synchronous, active-high reset.
- `a_req`  in  1  requester A has a write pending.
- `a_addr`  in  ADDR_W  requester A target register.
- `a_data`  in  DATA_W  requester A write value.
- `a_gnt`  out  1  requester A write accepted this cycle.
- `b_req`, `b_addr`, `b_data`, `b_gnt`: same roles as the A ports, for requester B.
- `init_busy`  out  1  zero-initialisation in progress.
- `wr_en`  out  1  registered write enable to the register file.
- `write_addr`  out  ADDR_W  registered write address.
- `write_data`  out  DATA_W  registered write data.

## Operation
States:
- **INIT**: a counter `cnt` steps 0..NUM_REGS-1, one step per cycle. Each cycle loads the output registers with `wr_en=1`, `write_addr=cnt`, `write_data=0`.
  - `init_busy=1`; `a_gnt=b_gnt=0`.
  - When `cnt==NUM_REGS-1`, the next state is RUN.
- **RUN**: `init_busy=0`. Grants are combinational from the requests and the priority pointer `last`.
  - Only A requesting: `a_gnt=1`.
  - Only B requesting: `b_gnt=1`.
  - Both requesting: grant the requester not recorded in `last`.
  - At most one grant per cycle.
  - On any grant, `last` becomes the granted requester. With no grant, `last` holds.
  - On the next edge the output registers load `wr_en=1`, `write_addr`/`write_data` from the granted requester. With no grant they load `wr_en=0`; addr/data hold their previous values.

Handshake rules:
- A transfer completes in the cycle where `req && gnt`.
- A requester holds `req`, addr and data stable until granted. It may present a new write in the cycle after its grant.
- Deasserting `req` before grant is legal: the request is withdrawn and nothing is written.

Reset:
- Reset values: `wr_en=0`, `write_addr=0`, `write_data=0`, `a_gnt=b_gnt=0`, `init_busy=1` (0 when the macro is off), `cnt=0`, `last=B` (A wins the first tie).
- `a_gnt`/`b_gnt` are forced to 0 in any cycle with `reset` high.
- Reset mid-INIT restarts the counter at 0. Reset mid-RUN drops any ungranted request, and no write is issued for it.

Other rules:
- Both requesters targeting the same address is not a conflict: the writes are serialised in grant order, so the last granted value persists.
- Requests during INIT are ignored (no grant). They remain pending into RUN.

## Timing
Cycle 0 is the first cycle with `reset` low.
- INIT occupies cycles 0..NUM_REGS-1.
- Register-file-facing `wr_en=1` with `write_addr=k` appears in cycle k+1, for k=0..15 (i.e. cycles 1..16).
- `init_busy` falls at the start of cycle 16. The first grant is possible in cycle 16, and its write appears in cycle 17.
- Grant latency is 0 cycles from `req` (same cycle). Write-port latency is 1 cycle after the grant, and the register file captures on the following edge.
- Sustained throughput is one write per cycle. Under continuous dual requests, grants alternate A, B, A, B...

## Configuration
- `REG_ARB_ZERO_INIT_EN` defined: the INIT state and counter are present, as described above.
- Undefined: no INIT state or counter. The block enters RUN in cycle 0 and `init_busy` is tied 0. The first grant is possible in cycle 0, and register contents after reset are undefined.

## Test plan
- Release reset with both requests low (macro on): `wr_en=1` in cycles 1..16 with `write_addr` 0..15 and `write_data=0`; `init_busy` low from cycle 16; `wr_en=0` in cycle 17.
- Hold `a_req=1`, `a_addr=3`, `a_data=32'hDEAD_BEEF` from cycle 5: no grant until cycle 16; `a_gnt=1` in cycle 16; `wr_en=1`, `write_addr=3`, `write_data=32'hDEAD_BEEF` in cycle 17.
- In RUN, raise both requests for 4 cycles with new data each cycle (A: addr 1, B: addr 2): grants A, B, A, B; the write port shows addr 1, 2, 1, 2 one cycle later.
- Same address from both (A: addr 7 = 32'h1, B: addr 7 = 32'h2) in the same cycle with `last=B`: A is granted first, then B; the final register-file read of address 7 is 32'h2.
- Assert `reset` in cycle 8 of INIT for one cycle: the counter restarts, and 16 fresh writes to addresses 0..15 follow the release.
- Macro undefined: `b_req=1`, `b_addr=15`, `b_data=32'h5` in cycle 0: `b_gnt=1` in cycle 0; the write to address 15 appears in cycle 1; `init_busy` stays 0 throughout.
